// File: rtl/multi_engine_rd_arbiter.sv
// Shares one AXI4 read master among NUM_ENGINES read engines: round-robin AR arbitration,
// R routing by upper rid bits, per-engine outstanding limits and sticky error flags.
// Optional stall counters: define MULTI_ENGINE_RD_PERF_EN.
module multi_engine_rd_arbiter #(
  parameter int unsigned NUM_ENGINES     = 4,
  parameter int unsigned ID_WIDTH        = 5,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 1024,
  parameter int unsigned ARUSER_WIDTH    = 8,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [NUM_ENGINES-1:0]                                s_arvalid,
  output logic [NUM_ENGINES-1:0]                                s_arready,
  input  logic [NUM_ENGINES*ADDR_WIDTH-1:0]                     s_araddr,
  input  logic [NUM_ENGINES*8-1:0]                              s_arlen,
  input  logic [NUM_ENGINES*(ID_WIDTH-$clog2(NUM_ENGINES))-1:0] s_arid,
  input  logic [NUM_ENGINES*ARUSER_WIDTH-1:0]                   s_aruser,
  output logic [NUM_ENGINES-1:0]                                s_rvalid,
  input  logic [NUM_ENGINES-1:0]                                s_rready,
  output logic [ID_WIDTH-$clog2(NUM_ENGINES)-1:0]               s_rid,
  output logic [DATA_WIDTH-1:0]                                 s_rdata,
  output logic [1:0]                                            s_rresp,
  output logic                                                  s_rlast,
  output logic                                                  m_axi_arvalid,
  input  logic                                                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0]                                 m_axi_araddr,
  output logic [7:0]                                            m_axi_arlen,
  output logic [ID_WIDTH-1:0]                                   m_axi_arid,
  output logic [ARUSER_WIDTH-1:0]                               m_axi_aruser,
  output logic [2:0]                                            m_axi_arsize,
  output logic [1:0]                                            m_axi_arburst,
  input  logic                                                  m_axi_rvalid,
  output logic                                                  m_axi_rready,
  input  logic [ID_WIDTH-1:0]                                   m_axi_rid,
  input  logic [DATA_WIDTH-1:0]                                 m_axi_rdata,
  input  logic [1:0]                                            m_axi_rresp,
  input  logic                                                  m_axi_rlast,
  input  logic                                                  err_clear,
  output logic [NUM_ENGINES-1:0]                                rd_error,
  output logic [NUM_ENGINES-1:0]                                outstanding_busy,
  output logic                                                  idle,
  output logic [NUM_ENGINES*32-1:0]                             perf_stall_cnt
);

  localparam int unsigned ENGW = $clog2(NUM_ENGINES);
  localparam int unsigned EIDW = ID_WIDTH - ENGW;
  localparam logic [7:0]  CNT_MAX = 8'(MAX_OUTSTANDING);

  logic [7:0]              cnt_q [NUM_ENGINES];
  logic [7:0]              cnt_d [NUM_ENGINES];
  logic [ENGW-1:0]         rr_q, rr_d;
  logic                    ar_vld_q, ar_vld_d;
  logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
  logic [7:0]              ar_len_q, ar_len_d;
  logic [ID_WIDTH-1:0]     ar_id_q, ar_id_d;
  logic [ARUSER_WIDTH-1:0] ar_user_q, ar_user_d;
  logic [NUM_ENGINES-1:0]  err_q, err_d;

  logic [NUM_ENGINES-1:0]  elig;
  logic                    grant_any;
  logic [ENGW-1:0]         grant_idx, scan_idx;
  logic                    ar_load;
  logic [ENGW-1:0]         r_eng;
  logic                    r_hs, r_done;
  logic [NUM_ENGINES-1:0]  r_dec;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++)
      elig[i] = s_arvalid[i] && (cnt_q[i] < CNT_MAX);
  end

  // First eligible engine at or after the RR pointer; power-of-2 count makes the add wrap.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
      scan_idx = rr_q + ENGW'(k);
      if (!grant_any && elig[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    ar_load   = grant_any && !rst && (!ar_vld_q || m_axi_arready);
    s_arready = '0;
    if (ar_load) s_arready[grant_idx] = 1'b1;
  end

  always_comb begin
    r_eng               = m_axi_rid[ID_WIDTH-1:EIDW];
    s_rvalid            = '0;
    s_rvalid[r_eng]     = m_axi_rvalid;
    m_axi_rready        = s_rready[r_eng];
    r_hs                = m_axi_rvalid && m_axi_rready;
    r_done              = r_hs && m_axi_rlast;
    r_dec               = '0;
    r_dec[r_eng]        = r_done;
  end

  assign s_rid   = m_axi_rid[EIDW-1:0];
  assign s_rdata = m_axi_rdata;
  assign s_rresp = m_axi_rresp;
  assign s_rlast = m_axi_rlast;

  // Error set is applied after the clear so a same-cycle error survives err_clear.
  always_comb begin
    err_d = err_clear ? '0 : err_q;
    if (r_hs && (m_axi_rresp != 2'b00)) err_d[r_eng] = 1'b1;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s_arready[i] && !r_dec[i]) begin
        if (cnt_q[i] != 8'hFF) cnt_d[i] = cnt_q[i] + 8'd1;
      end else if (r_dec[i] && !s_arready[i]) begin
        if (cnt_q[i] == 8'd0) err_d[i] = 1'b1;
        else                  cnt_d[i] = cnt_q[i] - 8'd1;
      end
    end
  end

  always_comb begin
    ar_vld_d  = ar_load || (ar_vld_q && !m_axi_arready);
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    ar_id_d   = ar_id_q;
    ar_user_d = ar_user_q;
    rr_d      = rr_q;
    if (ar_load) begin
      ar_addr_d = s_araddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      ar_len_d  = s_arlen[grant_idx*8 +: 8];
      ar_id_d   = {grant_idx, s_arid[grant_idx*EIDW +: EIDW]};
      ar_user_d = s_aruser[grant_idx*ARUSER_WIDTH +: ARUSER_WIDTH];
      rr_d      = grant_idx + ENGW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '{default: '0};
      rr_q      <= '0;
      ar_vld_q  <= 1'b0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_id_q   <= '0;
      ar_user_q <= '0;
      err_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      ar_vld_q  <= ar_vld_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
      ar_id_q   <= ar_id_d;
      ar_user_q <= ar_user_d;
      err_q     <= err_d;
    end
  end

  assign m_axi_arvalid = ar_vld_q;
  assign m_axi_araddr  = ar_addr_q;
  assign m_axi_arlen   = ar_len_q;
  assign m_axi_arid    = ar_id_q;
  assign m_axi_aruser  = ar_user_q;
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH/8));
  assign m_axi_arburst = 2'b01;
  assign rd_error      = err_q;

  always_comb begin
    idle             = !ar_vld_q;
    outstanding_busy = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      outstanding_busy[i] = (cnt_q[i] != 8'd0);
      if (cnt_q[i] != 8'd0) idle = 1'b0;
    end
  end

`ifdef MULTI_ENGINE_RD_PERF_EN
  logic [31:0] perf_q [NUM_ENGINES];

  always_ff @(posedge clk) begin
    if (rst || err_clear) begin
      perf_q <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < NUM_ENGINES; i++)
        if (s_arvalid[i] && !s_arready[i] && (perf_q[i] != '1))
          perf_q[i] <= perf_q[i] + 32'd1;
    end
  end

  always_comb begin
    perf_stall_cnt = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++)
      perf_stall_cnt[i*32 +: 32] = perf_q[i];
  end
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/multi_engine_rd_arbiter.md
Name: multi_engine_rd_arbiter

Overview:
- Shares one AXI4 host-memory read master among NUM_ENGINES independent read engines. It is the next-generation, parametrised replacement for the dedicated one-engine read path in the action wrapper.
- AR channel: round-robin arbitration through a one-entry output register.
- Engine index is prepended to each engine's local ID. R beats are routed back by the upper rid bits.
- Per-engine outstanding-burst limits and sticky response-error flags.

Parameters:
- NUM_ENGINES, 4, engine count; power of 2, 2..16.
- ID_WIDTH, 5, AXI ID width on the master side. EIDW = ID_WIDTH - log2(NUM_ENGINES) is the engine-local ID width; EIDW must be at least 1.
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 1024, AXI data width.
- ARUSER_WIDTH, 8, aruser width.
- MAX_OUTSTANDING, 8, maximum in-flight bursts per engine; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_arvalid  in  NUM_ENGINES  per-engine request valid
- s_arready  out  NUM_ENGINES  per-engine request accept
- s_araddr  in  NUM_ENGINES*ADDR_WIDTH  engine i in slice i
- s_arlen  in  NUM_ENGINES*8  burst length minus 1
- s_arid  in  NUM_ENGINES*EIDW  engine-local ID
- s_aruser  in  NUM_ENGINES*ARUSER_WIDTH  context/user bits
- s_rvalid  out  NUM_ENGINES  beat valid, one-hot
- s_rready  in  NUM_ENGINES  per-engine beat ready
- s_rid  out  EIDW  local ID, broadcast to all engines
- s_rdata  out  DATA_WIDTH  broadcast
- s_rresp  out  2  broadcast
- s_rlast  out  1  broadcast
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_araddr  out  ADDR_WIDTH
- m_axi_arlen  out  8
- m_axi_arid  out  ID_WIDTH
- m_axi_aruser  out  ARUSER_WIDTH
- m_axi_arsize  out  3
- m_axi_arburst  out  2
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- m_axi_rid  in  ID_WIDTH
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rresp  in  2
- m_axi_rlast  in  1
- err_clear  in  1  pulse; clears rd_error
- rd_error  out  NUM_ENGINES  sticky; rresp != OKAY seen for engine i
- outstanding_busy  out  NUM_ENGINES  engine i has at least one burst in flight
- idle  out  1  all counters zero and m_axi_arvalid low
- perf_stall_cnt  out  NUM_ENGINES*32  see Optional Feature

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is synchronous and active-high.
  - Held at reset: m_axi_arvalid=0, s_arready=0, rd_error=0, all counters=0, RR pointer=0, idle=1.
  - Reset mid-burst: outstanding state and the output register are discarded; the bench must re-reset the master side as well.
- Constant outputs:
  - m_axi_arsize = log2(DATA_WIDTH/8); 7 at 1024 bits.
  - m_axi_arburst = 2'b01 (INCR).
- Eligibility: engine i is eligible when s_arvalid[i]=1 and cnt[i] < MAX_OUTSTANDING.
- Grant:
  - Combinational round-robin over eligible engines, starting at the RR pointer.
  - s_arready[i] = grant[i] & (~m_axi_arvalid | m_axi_arready). At most one bit is set per cycle.
- AR handshake on engine i:
  - Output register loads addr, len, user and arid = {i, s_arid_i}.
  - m_axi_arvalid=1 on the next cycle (one-cycle latency).
  - RR pointer <- (i+1) mod NUM_ENGINES.
  - cnt[i] increments.
- Output register:
  - Holds its contents stable while m_axi_arvalid=1 and m_axi_arready=0 (AXI rule).
  - Back-to-back issue: a new load and an m_axi_arready drain in the same cycle gives one request per cycle.
  - With no grant and m_axi_arready=1, m_axi_arvalid falls.
- No grant: RR pointer is unchanged.
- R routing (combinational, zero latency):
  - e = m_axi_rid[ID_WIDTH-1:EIDW].
  - s_rvalid[e] = m_axi_rvalid; m_axi_rready = s_rready[e].
  - s_rid = m_axi_rid[EIDW-1:0].
- Beat handshake with rlast: cnt[e] decrements.
- Counter collisions:
  - Increment and decrement on the same engine in the same cycle leave cnt unchanged.
  - The counter saturates at both ends and never wraps.
  - A decrement at 0 indicates a protocol fault: the count stays at 0 and rd_error[e] is set.
- Errors:
  - rresp != 0 on any handshaken beat sets rd_error[e].
  - err_clear clears all bits; a new error arriving in the same cycle as err_clear wins (bit set).
- Full at MAX_OUTSTANDING: that engine is skipped by arbitration; other engines continue.
- Derived status: outstanding_busy[i] = (cnt[i] != 0); idle is combinational from state.

Optional Feature:
- Macro MULTI_ENGINE_RD_PERF_EN.
- Defined: per engine, a 32-bit counter increments each cycle s_arvalid[i]=1 and s_arready[i]=0. It saturates at 0xFFFFFFFF, clears on rst or err_clear, and drives perf_stall_cnt.
- Undefined: no counter logic; perf_stall_cnt is tied to 0.

Test Plan:
- Single request: engine 2 requests addr=0x1000, len=3, id=1 with arready=1 -> m_axi_arvalid the next cycle, arid=5'b10_001, arsize=7. Four R beats with rid=0x11 -> only s_rvalid[2] asserts; busy[2] goes 1 then 0.
- Round robin: all 4 engines request continuously with arready=1 -> grant order 0,1,2,3,0,…; one AR per cycle; no engine starved.
- Backpressure: arready=0 for 5 cycles with engine 1 pending -> m_axi_ar* stable; s_arready=0; nothing lost; issue resumes on the first arready=1.
- Outstanding limit: MAX_OUTSTANDING=2, no R returns -> engine 0 accepts 2 requests then stalls while engine 3 still issues. One rlast for engine 0 -> engine 0 is accepted again.
- Simultaneous events: engine 1 AR accept and engine 1 rlast in the same cycle -> cnt unchanged. rresp=2 on a beat for engine 3 while err_clear pulses -> rd_error=4'b1000.
- Perf counter (macro defined): engine 0 held 10 cycles against arready=0 -> perf_stall_cnt[0] = 10 (one cycle of register latency included). With the macro undefined -> 0.
